// File: rtl/zbt_arbiter.sv
//------------------------------------------------------------------------------
// zbt_arbiter
//
// Shares one pipelined ZBT SRAM between three clients:
//   - the display read port (highest priority, may issue every cycle),
//   - a small write FIFO fed by the NTSC capture path,
//   - the tracker (CPU) read port (lowest priority, request/ack handshake).
// At most one ZBT operation issues per cycle.
//
// Parameters
//   WFIFO_DEPTH  depth of the video write FIFO in entries (count output is 3 bits)
//   RD_LATENCY   cycles from ram_addr issue to valid ram_read_data
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   wr_addr/wr_data/wr_we      video write push into the write FIFO
//   disp_req/disp_addr         display read request (sampled every cycle)
//   disp_data/disp_valid       display read return (valid is a 1-cycle pulse)
//   cpu_req/cpu_addr           tracker read request, held until cpu_ack
//   cpu_ack                    1-cycle grant, high in the cycle the read issues
//   cpu_data/cpu_valid         tracker read return (valid is a 1-cycle pulse)
//   ram_addr/ram_we_b          registered ZBT address and active-low write enable
//   ram_wdata/ram_drive        ZBT write data and bus-drive enable (issue + 2)
//   ram_read_data              ZBT read data
//   wfifo_count                current write FIFO occupancy
//   wfifo_overflow             sticky: a write was dropped on a full FIFO
//------------------------------------------------------------------------------
module zbt_arbiter #(
  parameter int WFIFO_DEPTH = 4,
  parameter int RD_LATENCY  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [18:0] wr_addr,
  input  logic [35:0] wr_data,
  input  logic        wr_we,
  input  logic        disp_req,
  input  logic [18:0] disp_addr,
  output logic [35:0] disp_data,
  output logic        disp_valid,
  input  logic        cpu_req,
  input  logic [18:0] cpu_addr,
  output logic        cpu_ack,
  output logic [35:0] cpu_data,
  output logic        cpu_valid,
  output logic [18:0] ram_addr,
  output logic        ram_we_b,
  output logic [35:0] ram_wdata,
  output logic        ram_drive,
  input  logic [35:0] ram_read_data,
  output logic [2:0]  wfifo_count,
  output logic        wfifo_overflow
);

  localparam int PW = (WFIFO_DEPTH > 1) ? $clog2(WFIFO_DEPTH) : 1;

  // Write FIFO storage: {address, data}
  logic [54:0]   fifo_mem [WFIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [2:0]    count;

  logic          fifo_empty;
  logic          fifo_full;
  logic          pop;
  logic          push;
  logic          drop;
  logic [18:0]   head_addr;
  logic [35:0]   head_data;

  // Read issued in the current cycle (stage 0 of the tag pipeline)
  logic                  rd_issue;
  logic                  rd_is_cpu;
  logic [RD_LATENCY-1:0] pipe_v;
  logic [RD_LATENCY-1:0] pipe_cpu;

  // Write data follows its address by two cycles
  logic        wv0;
  logic        wv1;
  logic [35:0] wd0;
  logic [35:0] wd1;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(WFIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pop only when the display port is idle; a push is allowed on a full
  // FIFO only if the same cycle frees a slot.
  always_comb begin
    fifo_empty = (count == 3'd0);
    fifo_full  = (count == 3'(WFIFO_DEPTH));
    pop        = !disp_req && !fifo_empty;
    push       = wr_we && (!fifo_full || pop);
    drop       = wr_we && fifo_full && !pop;
    {head_addr, head_data} = fifo_mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      fifo_mem[wr_ptr] <= {wr_addr, wr_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= 3'd0;
      wfifo_overflow <= 1'b0;
      ram_addr       <= '0;
      ram_we_b       <= 1'b1;
      ram_wdata      <= '0;
      ram_drive      <= 1'b0;
      cpu_ack        <= 1'b0;
      rd_issue       <= 1'b0;
      rd_is_cpu      <= 1'b0;
      pipe_v         <= '0;
      pipe_cpu       <= '0;
      wv0            <= 1'b0;
      wv1            <= 1'b0;
      wd0            <= '0;
      wd1            <= '0;
      disp_valid     <= 1'b0;
      disp_data      <= '0;
      cpu_valid      <= 1'b0;
      cpu_data       <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      if (push && !pop)      count <= count + 3'd1;
      else if (pop && !push) count <= count - 3'd1;
      if (drop) wfifo_overflow <= 1'b1;

      // Issue stage: ram_addr holds its last value when nothing issues
      ram_we_b  <= 1'b1;
      cpu_ack   <= 1'b0;
      rd_issue  <= 1'b0;
      rd_is_cpu <= 1'b0;
      wv0       <= 1'b0;
      if (disp_req) begin
        ram_addr <= disp_addr;
        rd_issue <= 1'b1;
      end else if (pop) begin
        ram_addr <= head_addr;
        ram_we_b <= 1'b0;
        wv0      <= 1'b1;
        wd0      <= head_data;
      end else if (cpu_req) begin
        ram_addr  <= cpu_addr;
        rd_issue  <= 1'b1;
        rd_is_cpu <= 1'b1;
        cpu_ack   <= 1'b1;
      end

      wv1       <= wv0;
      wd1       <= wd0;
      ram_drive <= wv1;
      if (wv1) ram_wdata <= wd1;

      // Tag pipeline: the last stage lines up with valid ram_read_data
      pipe_v[0]   <= rd_issue;
      pipe_cpu[0] <= rd_is_cpu;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_cpu[i] <= pipe_cpu[i-1];
      end

      disp_valid <= pipe_v[RD_LATENCY-1] && !pipe_cpu[RD_LATENCY-1];
      cpu_valid  <= pipe_v[RD_LATENCY-1] &&  pipe_cpu[RD_LATENCY-1];
      if (pipe_v[RD_LATENCY-1] && !pipe_cpu[RD_LATENCY-1]) disp_data <= ram_read_data;
      if (pipe_v[RD_LATENCY-1] &&  pipe_cpu[RD_LATENCY-1]) cpu_data  <= ram_read_data;
    end
  end

  assign wfifo_count = count;

endmodule

// File: tb/tb_zbt_arbiter.sv
//------------------------------------------------------------------------------
// tb_zbt_arbiter
//
// Directed testbench for zbt_arbiter. Inputs are driven and outputs sampled
// 1 ns after each rising edge. A small ZBT model returns {17'h15A5A, addr}
// two cycles after a read address is presented.
//------------------------------------------------------------------------------
module tb_zbt_arbiter;

  logic        clk;
  logic        reset;
  logic [18:0] wr_addr;
  logic [35:0] wr_data;
  logic        wr_we;
  logic        disp_req;
  logic [18:0] disp_addr;
  logic [35:0] disp_data;
  logic        disp_valid;
  logic        cpu_req;
  logic [18:0] cpu_addr;
  logic        cpu_ack;
  logic [35:0] cpu_data;
  logic        cpu_valid;
  logic [18:0] ram_addr;
  logic        ram_we_b;
  logic [35:0] ram_wdata;
  logic        ram_drive;
  logic [35:0] ram_read_data;
  logic [2:0]  wfifo_count;
  logic        wfifo_overflow;

  int errors = 0;
  int checks = 0;

  zbt_arbiter #(.WFIFO_DEPTH(4), .RD_LATENCY(2)) dut (
    .clk(clk),
    .reset(reset),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_we(wr_we),
    .disp_req(disp_req),
    .disp_addr(disp_addr),
    .disp_data(disp_data),
    .disp_valid(disp_valid),
    .cpu_req(cpu_req),
    .cpu_addr(cpu_addr),
    .cpu_ack(cpu_ack),
    .cpu_data(cpu_data),
    .cpu_valid(cpu_valid),
    .ram_addr(ram_addr),
    .ram_we_b(ram_we_b),
    .ram_wdata(ram_wdata),
    .ram_drive(ram_drive),
    .ram_read_data(ram_read_data),
    .wfifo_count(wfifo_count),
    .wfifo_overflow(wfifo_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [35:0] ram_model(input logic [18:0] a);
    return {17'h15A5A, a};
  endfunction

  // ZBT model: address seen in cycle N yields data during cycle N+2
  logic [18:0] a1, a2;
  logic        r1, r2;
  always @(posedge clk) begin
    a1 <= ram_addr;
    r1 <= ram_we_b;
    a2 <= a1;
    r2 <= r1;
  end
  assign ram_read_data = r2 ? ram_model(a2) : 36'h0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset with all request inputs high: they must be ignored
    reset = 1'b1; wr_we = 1'b1; disp_req = 1'b1; cpu_req = 1'b1;
    wr_addr = 19'h7FFFF; wr_data = 36'hFFFFFFFFF; disp_addr = 19'h11111; cpu_addr = 19'h22222;
    tick(); tick();
    check_output("rst_count", wfifo_count, 3'd0);
    check_output("rst_ovf", wfifo_overflow, 1'b0);
    check_output("rst_we_b", ram_we_b, 1'b1);
    check_output("rst_drive", ram_drive, 1'b0);
    check_output("rst_addr", ram_addr, 19'h0);
    check_output("rst_dvalid", disp_valid, 1'b0);
    check_output("rst_cvalid", cpu_valid, 1'b0);
    check_output("rst_ack", cpu_ack, 1'b0);
    check_output("rst_ddata", disp_data, 36'h0);
    check_output("rst_cdata", cpu_data, 36'h0);

    reset = 1'b0; wr_we = 1'b0; disp_req = 1'b0; cpu_req = 1'b0;
    tick(); tick(); tick(); tick();
    check_output("post_rst_count", wfifo_count, 3'd0);
    check_output("post_rst_we_b", ram_we_b, 1'b1);
    check_output("post_rst_dvalid", disp_valid, 1'b0);
    check_output("post_rst_cvalid", cpu_valid, 1'b0);

    // Single write
    $display("[TB] single write");
    wr_addr = 19'h00010; wr_data = 36'h123456789; wr_we = 1'b1;
    tick();
    wr_we = 1'b0;
    check_output("wr_pushed_count", wfifo_count, 3'd1);
    check_output("wr_no_bypass", ram_we_b, 1'b1);
    tick();
    check_output("wr_issue_we_b", ram_we_b, 1'b0);
    check_output("wr_issue_addr", ram_addr, 19'h00010);
    check_output("wr_issue_count", wfifo_count, 3'd0);
    check_output("wr_issue_drive", ram_drive, 1'b0);
    tick();
    check_output("wr_n1_we_b", ram_we_b, 1'b1);
    check_output("wr_n1_drive", ram_drive, 1'b0);
    check_output("wr_n1_addr_hold", ram_addr, 19'h00010);
    tick();
    check_output("wr_n2_drive", ram_drive, 1'b1);
    check_output("wr_n2_wdata", ram_wdata, 36'h123456789);
    tick();
    check_output("wr_n3_drive", ram_drive, 1'b0);

    // Read priority: display before tracker
    $display("[TB] read priority");
    disp_addr = 19'h00100; cpu_addr = 19'h00200; disp_req = 1'b1; cpu_req = 1'b1;
    tick();
    disp_req = 1'b0;
    check_output("prio_disp_addr", ram_addr, 19'h00100);
    check_output("prio_disp_we_b", ram_we_b, 1'b1);
    check_output("prio_no_ack", cpu_ack, 1'b0);
    tick();
    cpu_req = 1'b0;
    check_output("prio_ack", cpu_ack, 1'b1);
    check_output("prio_cpu_addr", ram_addr, 19'h00200);
    tick();
    check_output("prio_ack_pulse", cpu_ack, 1'b0);
    check_output("prio_dvalid_early", disp_valid, 1'b0);
    tick();
    check_output("prio_dvalid", disp_valid, 1'b1);
    check_output("prio_ddata", disp_data, ram_model(19'h00100));
    check_output("prio_cvalid_early", cpu_valid, 1'b0);
    tick();
    check_output("prio_dvalid_pulse", disp_valid, 1'b0);
    check_output("prio_cvalid", cpu_valid, 1'b1);
    check_output("prio_cdata", cpu_data, ram_model(19'h00200));
    tick();
    check_output("prio_cvalid_pulse", cpu_valid, 1'b0);

    // Overflow while display starves the FIFO
    $display("[TB] overflow");
    disp_req = 1'b1; disp_addr = 19'h00300;
    for (int i = 0; i < 5; i++) begin
      wr_addr = 19'h01001 + 19'(i);
      wr_data = 36'hA00000000 + 36'(i);
      wr_we = 1'b1;
      tick();
      check_output("ovf_count", wfifo_count, (i < 4) ? 3'(i + 1) : 3'd4);
      check_output("ovf_flag", wfifo_overflow, (i == 4) ? 1'b1 : 1'b0);
    end
    wr_we = 1'b0; disp_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_output("ovf_drain_we_b", ram_we_b, 1'b0);
      check_output("ovf_drain_addr", ram_addr, 19'h01001 + 19'(k));
      if (k == 2) begin
        check_output("ovf_first_drive", ram_drive, 1'b1);
        check_output("ovf_first_wdata", ram_wdata, 36'hA00000000);
      end
    end
    tick();
    check_output("ovf_idle_we_b", ram_we_b, 1'b1);
    check_output("ovf_no_fifth", ram_addr, 19'h01004);
    check_output("ovf_empty", wfifo_count, 3'd0);
    check_output("ovf_sticky", wfifo_overflow, 1'b1);

    // Full FIFO with simultaneous push and pop
    $display("[TB] full push+pop");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_output("pp_ovf_cleared", wfifo_overflow, 1'b0);
    disp_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_addr = 19'h02001 + 19'(i);
      wr_data = 36'hB00000000 + 36'(i);
      wr_we = 1'b1;
      tick();
    end
    check_output("pp_full", wfifo_count, 3'd4);
    disp_req = 1'b0;
    wr_addr = 19'h02005; wr_data = 36'hB00000004; wr_we = 1'b1;
    tick();
    wr_we = 1'b0;
    check_output("pp_count", wfifo_count, 3'd4);
    check_output("pp_ovf", wfifo_overflow, 1'b0);
    check_output("pp_we_b", ram_we_b, 1'b0);
    check_output("pp_addr", ram_addr, 19'h02001);
    for (int k = 1; k < 5; k++) begin
      tick();
      check_output("pp_drain_addr", ram_addr, 19'h02001 + 19'(k));
      check_output("pp_drain_we_b", ram_we_b, 1'b0);
    end
    check_output("pp_drained", wfifo_count, 3'd0);

    // Reset one cycle after a display read issues
    $display("[TB] reset mid-read");
    disp_req = 1'b1; disp_addr = 19'h00400;
    tick();
    check_output("rmr_issue_addr", ram_addr, 19'h00400);
    disp_req = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    check_output("rmr_addr", ram_addr, 19'h0);
    check_output("rmr_we_b", ram_we_b, 1'b1);
    check_output("rmr_ddata", disp_data, 36'h0);
    check_output("rmr_count", wfifo_count, 3'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_output("rmr_no_dvalid", disp_valid, 1'b0);
      check_output("rmr_no_drive", ram_drive, 1'b0);
    end
    check_output("rmr_ddata_still0", disp_data, 36'h0);

    // Interleaved writes and display reads
    $display("[TB] interleave");
    disp_addr = 19'h00500;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        wr_addr = 19'h03000 + 19'(i); wr_data = 36'hC00000000 + 36'(i);
        wr_we = 1'b1; disp_req = 1'b0;
      end else begin
        wr_we = 1'b0; disp_req = 1'b1;
      end
      tick();
      check_output("il_count", wfifo_count, 3'd1);
      if (i % 2 == 1) begin
        check_output("il_disp_addr", ram_addr, 19'h00500);
        check_output("il_disp_we_b", ram_we_b, 1'b1);
      end else if (i >= 2) begin
        check_output("il_wr_addr", ram_addr, 19'h03000 + 19'(i - 2));
        check_output("il_wr_we_b", ram_we_b, 1'b0);
      end
    end
    wr_we = 1'b0; disp_req = 1'b0;
    tick();
    check_output("il_last_addr", ram_addr, 19'h03006);
    check_output("il_last_count", wfifo_count, 3'd0);

    // Tracker request held past its ack is a new request
    $display("[TB] tracker re-request");
    cpu_req = 1'b1; cpu_addr = 19'h00600;
    tick();
    check_output("cpu_ack1", cpu_ack, 1'b1);
    tick();
    cpu_req = 1'b0;
    check_output("cpu_ack2", cpu_ack, 1'b1);
    tick();
    check_output("cpu_ack_drop", cpu_ack, 1'b0);
    tick();
    check_output("cpu_valid1", cpu_valid, 1'b1);
    check_output("cpu_data1", cpu_data, ram_model(19'h00600));
    tick();
    check_output("cpu_valid2", cpu_valid, 1'b1);
    tick();
    check_output("cpu_valid_end", cpu_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
